sample_arbiter: RTL and testbench

Round-robin scheduler that shares the 4-bit `sample` input of the `fsm` datapath between four requesters. It grants one requester at a time and captures that requester's 4-bit sample. It drives the captured value onto the `fsm` `sample` input for exactly `HOLD_CYCLES` clock cycles, then re-arbitrates. It sits directly in front of `fsm` and is the only driver of that module's `sample` port.

---
 rtl/sample_arbiter.sv | 112 +++++++++++
 tb/tb_sample_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_arbiter.sv
// sample_arbiter
//   Round-robin scheduler sharing the 4-bit fsm sample input between four
//   requesters. A granted requester's sample is captured and held on
//   `sample` for HOLD_CYCLES cycles, after which the block re-arbitrates
//   (back-to-back with no idle cycle when requests are pending).
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   req[3:0]    in   request lines, one per requester
//   req_sample  in   packed samples, requester i at [4*i+3:4*i]
//   ack[3:0]    out  one-hot, one-cycle capture acknowledge (registered)
//   sample[3:0] out  captured sample presented to fsm.sample (registered)
//   busy        out  high while a granted sample is being held
//   owner[1:0]  out  index of the requester whose sample is on `sample`
module sample_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] req_sample,
    output logic [3:0]  ack,
    output logic [3:0]  sample,
    output logic        busy,
    output logic [1:0]  owner
);

    typedef enum logic {IDLE, HOLD} state_e;

    localparam logic [3:0] CNT_INIT = 4'(HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  sample_q, sample_d;
    logic [3:0]  ack_q, ack_d;
    logic        busy_q, busy_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [3:0]  elig;
    logic        found;
    logic [1:0]  win;
    logic [1:0]  idx;

    // Masking the requester acked this cycle keeps a HOLD_CYCLES=1 grant
    // from re-granting the same, already-consumed sample.
    always_comb begin
        elig  = req & ~ack_q;
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        ack_d    = 4'b0000;
        busy_d   = busy_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        if (state_q == HOLD && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else if (found) begin
            // Same grant path from IDLE and from HOLD expiry.
            state_d    = HOLD;
            sample_d   = req_sample[{win, 2'b00} +: 4];
            owner_d    = win;
            ack_d[win] = 1'b1;
            ptr_d      = win + 2'd1;
            cnt_d      = CNT_INIT;
            busy_d     = 1'b1;
        end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sample_q <= 4'b0000;
            ack_q    <= 4'b0000;
            busy_q   <= 1'b0;
            owner_q  <= 2'd0;
            ptr_q    <= 2'd0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ack    = ack_q;
    assign sample = sample_q;
    assign busy   = busy_q;
    assign owner  = owner_q;

endmodule

// File: tb/tb_sample_arbiter.sv
module tb_sample_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_i  [4];
    logic [15:0] samp_i [4];
    logic [3:0]  ack_o  [4];
    logic [3:0]  sample_o [4];
    logic        busy_o [4];
    logic [1:0]  owner_o [4];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         inst;
        int         cyc;
        logic [3:0] ack;
        logic [3:0] sample;
        logic [1:0] owner;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance g uses HOLD_CYCLES = g+1; only one instance is driven at a time.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        sample_arbiter #(.HOLD_CYCLES(g + 1)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req        (req_i[g]),
            .req_sample (samp_i[g]),
            .ack        (ack_o[g]),
            .sample     (sample_o[g]),
            .busy       (busy_o[g]),
            .owner      (owner_o[g])
        );
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int inst, input int c, input logic [3:0] a,
                        input logic [3:0] s, input logic [1:0] o);
        exp_t e;
        e.inst = inst; e.cyc = c; e.ack = a; e.sample = s; e.owner = o;
        exp_q.push_back(e);
    endtask

    // Monitor: every ack pulse is a DUT output event, matched against the queue.
    always @(negedge clk) begin
        for (int h = 0; h < 4; h++) begin
            if (ack_o[h] != 4'b0000) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack: inst %0d ack %b at cycle %0d, none expected", h, ack_o[h], cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.inst != h || e.cyc != cyc || e.ack !== ack_o[h] ||
                        e.sample !== sample_o[h] || e.owner !== owner_o[h]) begin
                        n_fail++;
                        $display("FAIL grant: got inst %0d cyc %0d ack %b sample %h owner %0d, expected inst %0d cyc %0d ack %b sample %h owner %0d",
                                 h, cyc, ack_o[h], sample_o[h], owner_o[h],
                                 e.inst, e.cyc, e.ack, e.sample, e.owner);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int h = 0; h < 4; h++) begin
            req_i[h]  = 4'b0000;
            samp_i[h] = 16'h0000;
        end
        repeat (2) @(negedge clk);
        chk("reset_ack", {4'b0, ack_o[0]}, 8'h00);
        chk("reset_sample", {4'b0, sample_o[0]}, 8'h00);
        chk("reset_busy", {7'b0, busy_o[0]}, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // Round-robin, HOLD_CYCLES=1, samples 1..4 on requesters 0..3.
        t = cyc;
        req_i[0]  = 4'b1111;
        samp_i[0] = 16'h4321;
        push(0, t + 1, 4'b0001, 4'h1, 2'd0);
        push(0, t + 2, 4'b0010, 4'h2, 2'd1);
        push(0, t + 3, 4'b0100, 4'h3, 2'd2);
        push(0, t + 4, 4'b1000, 4'h4, 2'd3);
        push(0, t + 5, 4'b0001, 4'h1, 2'd0);
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-cycle with all requests still held.
        #1 reset = 1'b1;
        #1;
        chk("async_rst_ack", {4'b0, ack_o[0]}, 8'h00);
        chk("async_rst_sample", {4'b0, sample_o[0]}, 8'h00);
        chk("async_rst_busy", {7'b0, busy_o[0]}, 8'h00);
        chk("async_rst_owner", {6'b0, owner_o[0]}, 8'h00);
        repeat (2) @(negedge clk);
        push(0, cyc + 1, 4'b0001, 4'h1, 2'd0);
        reset = 1'b0;
        @(negedge clk);
        req_i[0] = 4'b0000;
        repeat (3) @(negedge clk);

        // Single requester 2, then a second sample after the ack.
        t = cyc;
        req_i[0]  = 4'b0100;
        samp_i[0] = 16'h0A00;
        push(0, t + 1, 4'b0100, 4'hA, 2'd2);
        @(negedge clk);
        samp_i[0] = 16'h0300;
        push(0, t + 3, 4'b0100, 4'h3, 2'd2);
        @(negedge clk);
        chk("single_gap_sample", {4'b0, sample_o[0]}, 8'h0A);
        @(negedge clk);
        req_i[0] = 4'b0000;
        repeat (3) @(negedge clk);

        // Hold length 3, requesters 0 and 1: grants every 3 cycles, busy solid.
        t = cyc;
        req_i[2]  = 4'b0011;
        samp_i[2] = 16'h0065;
        push(2, t + 1, 4'b0001, 4'h5, 2'd0);
        push(2, t + 4, 4'b0010, 4'h6, 2'd1);
        push(2, t + 7, 4'b0001, 4'h5, 2'd0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("hold3_busy", {7'b0, busy_o[2]}, 8'h01);
            if (i == 3) chk("hold3_sample0", {4'b0, sample_o[2]}, 8'h05);
            if (i == 6) chk("hold3_sample1", {4'b0, sample_o[2]}, 8'h06);
            if (i == 7) req_i[2] = 4'b0000;
        end
        @(negedge clk);
        chk("hold3_busy_fall", {7'b0, busy_o[2]}, 8'h00);
        chk("hold3_sample_kept", {4'b0, sample_o[2]}, 8'h05);

        // Idle return with HOLD_CYCLES=2, then requester 3 alone.
        t = cyc;
        req_i[1]  = 4'b0001;
        samp_i[1] = 16'h0007;
        push(1, t + 1, 4'b0001, 4'h7, 2'd0);
        @(negedge clk);
        req_i[1] = 4'b0000;
        @(negedge clk);
        chk("idle_busy_hold", {7'b0, busy_o[1]}, 8'h01);
        @(negedge clk);
        chk("idle_busy_fall", {7'b0, busy_o[1]}, 8'h00);
        chk("idle_sample_kept", {4'b0, sample_o[1]}, 8'h07);
        repeat (2) @(negedge clk);
        chk("idle_sample_kept2", {4'b0, sample_o[1]}, 8'h07);
        req_i[1]  = 4'b1000;
        samp_i[1] = 16'h9000;
        push(1, cyc + 1, 4'b1000, 4'h9, 2'd3);
        @(negedge clk);
        req_i[1] = 4'b0000;
        repeat (3) @(negedge clk);

        // Withdrawn request with HOLD_CYCLES=4: req[1] never acked.
        req_i[3]  = 4'b0001;
        samp_i[3] = 16'h00BA;
        push(3, cyc + 1, 4'b0001, 4'hA, 2'd0);
        @(negedge clk);
        req_i[3] = 4'b0010;
        repeat (2) @(negedge clk);
        req_i[3] = 4'b0000;
        @(negedge clk);
        chk("withdraw_busy_hold", {7'b0, busy_o[3]}, 8'h01);
        @(negedge clk);
        chk("withdraw_busy_fall", {7'b0, busy_o[3]}, 8'h00);
        repeat (4) @(negedge clk);

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_grants: %0d expected grants never seen, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
